// File: rtl/seg7_pkg.sv
// Shared seven-segment display types, segment constants and the hex glyph lookup.
package seg7_pkg;

  localparam int unsigned DIGIT_W          = 2;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned NUM_DIGITS_FIXED = 4;
  localparam int unsigned VALUE_W          = NUM_DIGITS_FIXED * NIBBLE_W;

  typedef logic [DIGIT_W-1:0]  digit_idx_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [SEG_W-1:0]    seg_t;

  // Active-low segment pattern that turns every segment off.
  localparam seg_t SEG_OFF = 7'h7F;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;

  // Registered display drive, all fields active-low except frame_start.
  typedef struct packed {
    logic [NUM_DIGITS_FIXED-1:0] an;
    seg_t                        seg;
    logic                        dp;
    logic                        frame_start;
  } display_t;

  function automatic seg_t hex_seg_on(input nibble_t n);
    seg_t s;
    case (n)
      4'h0:    s = SEG_HEX_0;
      4'h1:    s = SEG_HEX_1;
      4'h2:    s = SEG_HEX_2;
      4'h3:    s = SEG_HEX_3;
      4'h4:    s = SEG_HEX_4;
      4'h5:    s = SEG_HEX_5;
      4'h6:    s = SEG_HEX_6;
      4'h7:    s = SEG_HEX_7;
      4'h8:    s = SEG_HEX_8;
      4'h9:    s = SEG_HEX_9;
      4'hA:    s = SEG_HEX_A;
      4'hB:    s = SEG_HEX_B;
      4'hC:    s = SEG_HEX_C;
      4'hD:    s = SEG_HEX_D;
      4'hE:    s = SEG_HEX_E;
      default: s = SEG_HEX_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder, shared by display blocks.
module hex_to_seg
  import seg7_pkg::*;
(
  input  nibble_t nibble,
  output seg_t    seg_c
);

  always_comb begin
    seg_c = ~hex_seg_on(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 16-bit value onto a 4-digit common-anode display, one digit per synchronised scan_clock edge.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits of each frame.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        scan_clock,
  input  logic [VALUE_W-1:0]          value,
  input  logic [NUM_DIGITS_FIXED-1:0] dp_in,
  input  logic [NUM_DIGITS_FIXED-1:0] digit_en,
  input  logic                        blank,
  output logic [NUM_DIGITS_FIXED-1:0] an,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic                        frame_start
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("seg7_scan_driver: SYNC_STAGES must be in 2..4");
  end
  if (NUM_DIGITS != NUM_DIGITS_FIXED) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 4");
  end

  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        edge_q;
  logic                        sync_out_c;
  logic                        tick_c;

  digit_idx_t                  index_q;
  digit_idx_t                  index_nxt_c;
  logic                        snap_c;
  logic [VALUE_W-1:0]          frame_value_q;
  logic [VALUE_W-1:0]          frame_value_nxt_c;
  logic [NUM_DIGITS_FIXED-1:0] frame_dp_q;
  logic [NUM_DIGITS_FIXED-1:0] frame_dp_nxt_c;
  logic                        active_q;
  logic                        active_nxt_c;

  nibble_t                     nibble_c;
  seg_t                        seg_lut_c;
  logic [NUM_DIGITS_FIXED-1:0] onehot_c;
  logic [NUM_DIGITS_FIXED-1:0] lz_mask_c;
  display_t                    disp_q;
  display_t                    disp_nxt_c;

  // scan_clock is asynchronous data: resynchronise, then detect its rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clock};
      edge_q <= sync_out_c;
    end
  end

  assign sync_out_c = sync_q[SYNC_STAGES-1];
  assign tick_c     = sync_out_c & ~edge_q;

  // Next index and frame snapshot; a frame is captured whole as digit 0 comes up.
  always_comb begin
    index_nxt_c = index_q;
    if (tick_c) begin
      index_nxt_c = digit_idx_t'(index_q + digit_idx_t'(1));
    end
    snap_c            = tick_c && (index_nxt_c == digit_idx_t'(0));
    frame_value_nxt_c = snap_c ? value : frame_value_q;
    frame_dp_nxt_c    = snap_c ? dp_in : frame_dp_q;
    active_nxt_c      = active_q | snap_c;
  end

  // Index resets to 3 so the first tick after reset starts a fresh frame at digit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_q       <= digit_idx_t'(NUM_DIGITS_FIXED - 1);
      frame_value_q <= '0;
      frame_dp_q    <= '0;
      active_q      <= 1'b0;
    end else begin
      index_q       <= index_nxt_c;
      frame_value_q <= frame_value_nxt_c;
      frame_dp_q    <= frame_dp_nxt_c;
      active_q      <= active_nxt_c;
    end
  end

  assign nibble_c = frame_value_nxt_c[{index_nxt_c, 2'b00} +: NIBBLE_W];
  assign onehot_c = NUM_DIGITS_FIXED'(1) << index_nxt_c;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_c),
    .seg_c  (seg_lut_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Keep digits up to the most significant nonzero nibble of the snapshot; digit 0 always shows.
  always_comb begin
    lz_mask_c = 4'b0001;
    if (frame_value_nxt_c[15:12] != 4'h0) begin
      lz_mask_c = 4'b1111;
    end else if (frame_value_nxt_c[11:8] != 4'h0) begin
      lz_mask_c = 4'b0111;
    end else if (frame_value_nxt_c[7:4] != 4'h0) begin
      lz_mask_c = 4'b0011;
    end
  end
`else
  assign lz_mask_c = '1;
`endif

  // Output drive stays dark until the first frame after reset has been captured.
  always_comb begin
    disp_nxt_c.an          = '1;
    disp_nxt_c.seg         = SEG_OFF;
    disp_nxt_c.dp          = 1'b1;
    disp_nxt_c.frame_start = snap_c;
    if (active_nxt_c) begin
      if (!blank) begin
        disp_nxt_c.an = ~(onehot_c & digit_en & lz_mask_c);
      end
      disp_nxt_c.seg = seg_lut_c;
      disp_nxt_c.dp  = ~frame_dp_nxt_c[index_nxt_c];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_q.an          <= '1;
      disp_q.seg         <= SEG_OFF;
      disp_q.dp          <= 1'b1;
      disp_q.frame_start <= 1'b0;
    end else begin
      disp_q <= disp_nxt_c;
    end
  end

  assign an          = disp_q.an;
  assign seg         = disp_q.seg;
  assign dp          = disp_q.dp;
  assign frame_start = disp_q.frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised scoreboard bench for seg7_scan_driver against a slot-level display model.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        scan_clock;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          fs_exp = 0;
  int          fs_seen = 0;

  // Model state: displayed slot, frame snapshot, whether a frame has started.
  int          idx;
  bit          active;
  logic [15:0] fv;
  logic [3:0]  fd;
  bit          hist[$];
  bit          prev_rst;

  // Stimulus generator state.
  bit          sc_state;
  int          sc_cnt;
  int          sc_len;
  logic [15:0] cur_v;
  logic [3:0]  cur_d;
  logic [3:0]  cur_e;
  bit          cur_b;

  always #5 clock = ~clock;

  seg7_scan_driver #(.SYNC_STAGES(S), .NUM_DIGITS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .scan_clock  (scan_clock),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blank       (blank),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] shown_digits(input logic [15:0] f);
    int top = 0;
    for (int i = 0; i < 4; i++) begin
      if (((f >> (4 * i)) & 16'hF) != 16'h0) top = i;
    end
`ifdef LEADING_ZERO_BLANK_EN
    return 4'((1 << (top + 1)) - 1);
`else
    return (top < 4) ? 4'hF : 4'h0;
`endif
  endfunction

  // One clock of stimulus: drive inputs, then predict what the next edge displays.
  task automatic step(input bit r, input bit sc, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e, input bit b);
    exp_t x;
    bit   tick;
    int   nib;
    @(negedge clock);
    reset = r; scan_clock = sc; value = v; dp_in = d; digit_en = e; blank = b;
    if (r && !prev_rst) begin
      #1;
      chk("async_rst_an", 32'(an), 32'hF);
      chk("async_rst_seg", 32'(seg), 32'h7F);
      chk("async_rst_dp", 32'(dp), 32'h1);
      chk("async_rst_fs", 32'(frame_start), 32'h0);
    end
    prev_rst = r;
    if (r) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
      idx = 3; active = 0; fv = '0; fd = '0;
      x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.fs = 1'b0;
    end else begin
      hist.push_back(sc);
      void'(hist.pop_front());
      tick = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
      x.fs = 1'b0;
      if (tick) begin
        idx = (idx + 1) % 4;
        if (idx == 0) begin
          fv = v; fd = d; active = 1; x.fs = 1'b1; fs_exp++;
        end
      end
      x.an  = (b || !active) ? 4'hF : ~(4'(1 << idx) & e & shown_digits(fv));
      nib   = int'((fv >> (4 * idx)) & 16'hF);
      x.seg = active ? ~glyph(nib) : 7'h7F;
      x.dp  = active ? ~fd[idx] : 1'b1;
    end
    exp_q.push_back(x);
  endtask

  // mode 0: scan idle; 1: scanning with value churn; 2: blanking, sparse enables; 3: all random.
  task automatic run(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      if (mode == 0) begin
        sc_state = 0; sc_cnt = 0;
      end else begin
        sc_cnt++;
        if (sc_cnt >= sc_len) begin
          sc_state = !sc_state; sc_cnt = 0; sc_len = int'($urandom_range(2, 5));
        end
      end
      if (mode != 0 && $urandom_range(0, 39) == 0) cur_v = 16'($urandom);
      case (mode)
        1: begin
          cur_e = 4'hF; cur_b = 0;
          if ($urandom_range(0, 29) == 0) cur_d = 4'($urandom);
        end
        2: begin
          cur_e = 4'b0101; cur_d = 4'b0001;
          if ($urandom_range(0, 9) == 0) cur_b = !cur_b;
        end
        3: begin
          if ($urandom_range(0, 29) == 0) cur_e = 4'($urandom);
          if ($urandom_range(0, 29) == 0) cur_d = 4'($urandom);
          if ($urandom_range(0, 19) == 0) cur_b = !cur_b;
          if ($urandom_range(0, 3) == 0) cur_v = 16'($urandom);
        end
        default: ;
      endcase
      step(1'b0, sc_state, cur_v, cur_d, cur_e, cur_b);
    end
  endtask

  // Monitor: every edge the display register presents a new drive; compare against the queue head.
  always @(posedge clock) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      fs_seen += int'(frame_start);
      chk("an", 32'(an), 32'(x.an));
      chk("seg", 32'(seg), 32'(x.seg));
      chk("dp", 32'(dp), 32'(x.dp));
      chk("frame_start", 32'(frame_start), 32'(x.fs));
    end
  end

  initial begin
    reset = 1'b1; scan_clock = 1'b0; value = 16'h1234; dp_in = 4'h0;
    digit_en = 4'hF; blank = 1'b0;
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    idx = 3; active = 0; fv = '0; fd = '0; prev_rst = 1;
    sc_state = 0; sc_cnt = 0; sc_len = 3;
    cur_v = 16'h1234; cur_d = 4'h0; cur_e = 4'hF; cur_b = 0;
    #1;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_fs", 32'(frame_start), 32'h0);

    step(1'b1, 1'b0, cur_v, cur_d, cur_e, cur_b);
    step(1'b1, 1'b0, cur_v, cur_d, cur_e, cur_b);
    run(20, 0);
    run(300, 1);
    run(200, 2);

    // Reset in the middle of a frame, then restart from a quiet scan_clock.
    step(1'b1, 1'b0, cur_v, cur_d, cur_e, cur_b);
    step(1'b1, 1'b0, cur_v, cur_d, cur_e, cur_b);
    sc_state = 0; sc_cnt = 0;
    run(3, 0);
    cur_e = 4'hF; cur_b = 0;
    run(300, 3);

    @(posedge clock);
    #2;
    chk("frame_start_count", 32'(fs_seen), 32'(fs_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
